// File: rtl/axi_w_route_ctrl_pkg.sv
// Shared types and width helpers for the crossbar W-route control slice.
package xbar_pkg;

  localparam int unsigned NUM_IN  = 4;
  localparam int unsigned MAX_TXN = 4;

  // Index width for n inputs; never collapses to zero bits.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Counter width able to hold 0..max_txn inclusive.
  function automatic int unsigned cnt_w(input int unsigned max_txn);
    return $clog2(max_txn + 1);
  endfunction

  typedef logic [idx_w(NUM_IN)-1:0]  idx_t;
  typedef logic [cnt_w(MAX_TXN)-1:0] max_txn_cnt_t;

endpackage

// File: rtl/axi_w_route_ctrl_if.sv
// AW/W handshake bundle between the arbiter, the slave-port inputs and the
// downstream slave. Signal suffixes are from the route controller's view.
interface axi_w_route_ctrl_if import xbar_pkg::*; #(
  parameter int unsigned NumIn  = NUM_IN,
  parameter type         AwType = logic,
  parameter type         WType  = logic
);

  localparam int unsigned IdxW = idx_w(NumIn);

  // arbiter side
  logic                   arb_req_i;
  AwType                  arb_data_i;
  logic [IdxW-1:0]        arb_idx_i;
  logic                   arb_gnt_o;
  // AW towards the slave
  logic                   aw_valid_o;
  AwType                  aw_data_o;
  logic                   aw_ready_i;
  // W from the inputs
  logic [NumIn-1:0]       w_valid_i;
  logic [NumIn-1:0]       w_last_i;
  WType [NumIn-1:0]       w_data_i;
  logic [NumIn-1:0]       w_ready_o;
  // W towards the slave
  logic                   w_valid_o;
  logic                   w_last_o;
  WType                   w_data_o;
  logic                   w_ready_i;

  // Route controller view.
  modport slave (
    input  arb_req_i, arb_data_i, arb_idx_i, aw_ready_i,
           w_valid_i, w_last_i, w_data_i, w_ready_i,
    output arb_gnt_o, aw_valid_o, aw_data_o,
           w_ready_o, w_valid_o, w_last_o, w_data_o
  );

  // Environment view (arbiter, inputs and slave together).
  modport master (
    output arb_req_i, arb_data_i, arb_idx_i, aw_ready_i,
           w_valid_i, w_last_i, w_data_i, w_ready_i,
    input  arb_gnt_o, aw_valid_o, aw_data_o,
           w_ready_o, w_valid_o, w_last_o, w_data_o
  );

endinterface

// File: rtl/axi_w_route_ctrl_idx_fifo.sv
// In-order FIFO of granted input indices. Pointers wrap modulo Depth so the
// depth need not be a power of two. Flush wins over a same-cycle push/pop.
module idx_fifo import xbar_pkg::*; #(
  parameter int unsigned Depth = MAX_TXN,
  parameter int unsigned DataW = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [DataW-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [DataW-1:0] head_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = cnt_w(Depth);

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  logic [DataW-1:0] mem_q [Depth];
  ptr_t             wr_ptr_q, wr_ptr_d;
  ptr_t             rd_ptr_q, rd_ptr_d;
  cnt_t             cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (32'(p) == Depth - 1) ? '0 : p + ptr_t'(1);
  endfunction

  assign full_o  = (cnt_q == cnt_t'(Depth));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // Guard against overflow/underflow locally; the top never asks for either.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Next pointers and occupancy; push+pop together leaves the count alone.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + cnt_t'(1);
        2'b01:   cnt_d = cnt_q - cnt_t'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage; a push in a flush cycle is dropped along with the pointers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/axi_w_route_ctrl.sv
// W routing behind the AW round-robin arbiter of one crossbar master port.
// AW is a zero-latency passthrough; each accepted AW records its input index
// so W bursts are steered from that input, in AW order, until WLAST.
module axi_w_route_ctrl import xbar_pkg::*; #(
  parameter int unsigned NumIn  = NUM_IN,
  parameter int unsigned MaxTxn = MAX_TXN,
  parameter type         AwType = logic,
  parameter type         WType  = logic
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  axi_w_route_ctrl_if.slave bus,
  output logic              busy_o
);

  localparam int unsigned IdxW = idx_w(NumIn);

  logic             full, empty;
  logic             push, pop;
  logic [IdxW-1:0]  head;

  logic             aw_valid;
  AwType            aw_data;

  logic             w_valid, w_last;
  WType             w_data;
  logic [NumIn-1:0] w_ready;

  // ---------------- AW passthrough ----------------
  // Full stalls AW outright, even when a pop is landing this cycle, so there
  // is no combinational path from W completion to AW valid. Reset also masks
  // valid so nothing is offered while the port is being cleared.
  assign aw_valid       = rst_ni & bus.arb_req_i & ~full;
  assign aw_data        = bus.arb_data_i;
  assign push           = aw_valid & bus.aw_ready_i;

  assign bus.aw_valid_o = aw_valid;
  assign bus.aw_data_o  = aw_data;
  assign bus.arb_gnt_o  = push;

  // ---------------- route FIFO ----------------
  idx_fifo #(
    .Depth (MaxTxn),
    .DataW (IdxW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (push),
    .data_i  (bus.arb_idx_i),
    .pop_i   (pop),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (head)
  );

  assign busy_o = ~empty;

  // ---------------- W mux ----------------
  // Steer the head input to the slave; with nothing recorded, W stays
  // blocked so early beats wait for their AW.
  always_comb begin
    w_valid = 1'b0;
    w_last  = 1'b0;
    w_data  = '0;
    w_ready = '0;
    if (!empty) begin
      w_valid = bus.w_valid_i[head];
      w_last  = bus.w_last_i[head];
      w_data  = bus.w_data_i[head];
      w_ready = NumIn'(bus.w_ready_i) << head;
    end
  end

  // Burst ends on the last beat handshake; next head is live next cycle.
  assign pop = w_valid & bus.w_ready_i & w_last;

  assign bus.w_valid_o = w_valid;
  assign bus.w_last_o  = w_last;
  assign bus.w_data_o  = w_data;
  assign bus.w_ready_o = w_ready;

  // ---------------- checks ----------------
  a_idx_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
    bus.arb_req_i |-> (32'(bus.arb_idx_i) < NumIn));

  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push && full));

  a_wready_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(bus.w_ready_o));

  a_aw_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (bus.aw_valid_o && !bus.aw_ready_i) |=> $stable(bus.aw_data_o));

endmodule
